key_input_conditioner: RTL and testbench
========================================

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 The block SHALL have parameters, one per line:
- DEBOUNCE_CYCLES, 1_000_000, cycles a raw key must be stable before its debounced state changes.
- PULSE_CYCLES, 5_000_000, length of each ON pulse on an output key.
- REPEAT_DELAY, 25_000_000, OFF cycles after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000, OFF cycles between subsequent auto-repeat pulses.
REQ-002 The block SHALL have ports, one per line:
- clock, input, 1, system clock.
- resetApp, input, 1, asynchronous active-low reset.
- RawKey, input, 4, push buttons, active-low; bit 0 Left, 1 Right, 2 Up, 3 Down.
- KeyLeft, output, 1, conditioned Left, active-low (ON=0).
- KeyRight, output, 1, conditioned Right, active-low.
- KeyUp, output, 1, conditioned Up, active-low.
- KeyDown, output, 1, conditioned Down, active-low.
- KeyBusy, output, 1, high when the FSM is not in IDLE.
REQ-003 There SHALL be one clock domain (clock) and one reset, resetApp, which is asynchronous and active-low.

Function
REQ-004 Each RawKey bit SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1 (released).
REQ-005 Each key SHALL use a debounce counter. The counter increments while the synced value differs from the debounced state. It clears on any cycle where they match. The debounced state toggles and the counter clears when the count reaches DEBOUNCE_CYCLES-1.
REQ-006 Counter widths SHALL be $clog2 of the largest value they must hold; no counter SHALL wrap during normal operation.
REQ-007 A single FSM SHALL drive all outputs. Its states are IDLE, PULSE, DELAY, REPEAT.
REQ-008 In IDLE:
- All outputs are OFF (1).
- If any debounced key is pressed, ActiveKey is latched with priority Left>Right>Up>Down, the state becomes PULSE, and the counter is cleared.
REQ-009 In PULSE:
- Only the ActiveKey output is ON.
- After exactly PULSE_CYCLES cycles, the FSM goes to DELAY if this was the first pulse, otherwise to REPEAT.
- Release during PULSE SHALL NOT truncate the pulse.
REQ-010 In DELAY and REPEAT:
- All outputs are OFF.
- If the debounced ActiveKey is released, the FSM goes to IDLE the next cycle.
- Otherwise, after REPEAT_DELAY (DELAY) or REPEAT_PERIOD (REPEAT) cycles, the FSM re-enters PULSE.
REQ-011 Keys other than ActiveKey SHALL be ignored outside IDLE. If another key is still held on return to IDLE, it starts a new press sequence from IDLE.
REQ-012 At most one output SHALL be ON in any cycle.
REQ-013 Latency: the output SHALL go ON exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples RawKey low, provided RawKey is held stable.
REQ-014 KeyBusy SHALL be registered and equal (state != IDLE).

Reset
REQ-015 Asserting resetApp low SHALL immediately force:
- all key outputs to 1;
- KeyBusy to 0;
- FSM to IDLE;
- all counters to 0;
- debounced states to released.
REQ-016 Reset mid-pulse SHALL abort the pulse with no glitch to ON after deassertion unless a fresh debounced press occurs.

Structure
REQ-017 A shared package SHALL hold:
- ON=1'b0 and OFF=1'b1;
- key index constants (KEY_LEFT=0 ... KEY_DOWN=3);
- the FSM state encoding.
REQ-018 Synchronizer and debouncer SHALL form one sub-module, key_debouncer, instantiated 4 times. The FSM SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-019 Tap: RawKey[0] low for 20 cycles -> KeyLeft=0 from edge 7 for exactly 3 cycles, then 1; no repeat.
REQ-020 Bounce: RawKey[2] toggling every 2 cycles for 30 cycles -> KeyUp stays 1 throughout.
REQ-021 Hold: RawKey[3] low for 60 cycles -> KeyDown pulses start at edges 7, 20, 28, 36, ..., each pulse 3 cycles long.
REQ-022 Simultaneous: RawKey=4'b0000 from the same edge -> only KeyLeft pulses. Release Left while others are held -> KeyRight starts the next sequence.
REQ-023 Reset: resetApp low during the 2nd pulse cycle -> all outputs 1 asynchronously and KeyBusy=0. After release with the key held -> the first pulse occurs after a full DEBOUNCE_CYCLES+3 edges.
REQ-024 Assertion throughout all tests: at most one output is 0 in any cycle.

Source files
------------

// File: rtl/key_input_conditioner_pkg.sv
// Shared definitions for the key input conditioner: active-low levels,
// key indices, FSM state encoding and small helper functions.
package key_input_conditioner_pkg;

  // Keys and outputs are active-low.
  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;

  localparam logic [1:0] KEY_LEFT  = 2'd0;
  localparam logic [1:0] KEY_RIGHT = 2'd1;
  localparam logic [1:0] KEY_UP    = 2'd2;
  localparam logic [1:0] KEY_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Fixed priority Left > Right > Up > Down among pressed keys (1 = pressed).
  function automatic logic [1:0] pick_key(input logic [3:0] pressed);
    if (pressed[KEY_LEFT])       return KEY_LEFT;
    else if (pressed[KEY_RIGHT]) return KEY_RIGHT;
    else if (pressed[KEY_UP])    return KEY_UP;
    else                         return KEY_DOWN;
  endfunction

endpackage

// File: rtl/key_input_conditioner_debouncer.sv
// One key: 2-flop synchronizer followed by a stability counter. The
// debounced level only changes after the synced level has differed from
// it for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
  import key_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic resetApp,
  input  logic raw,
  output logic debounced
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // Synchronizer; resets to released so a reset never looks like a press.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      sync1 <= OFF;
      sync2 <= OFF;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter: any agreement restarts the count.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      cnt   <= '0;
      deb_q <= OFF;
    end else if (sync2 == deb_q) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      deb_q <= ~deb_q;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Four-key conditioner: debounced keys feed a single FSM that emits a
// fixed-length ON pulse on press, then auto-repeats while the key is held.
// Outputs and KeyBusy are registered from the next-state decode so they
// are glitch-free and line up with the state register.
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_CYCLES    = 5_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic [3:0] RawKey,
  output logic       KeyLeft,
  output logic       KeyRight,
  output logic       KeyUp,
  output logic       KeyDown,
  output logic       KeyBusy
);

  localparam int CW = cnt_width(max3(PULSE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [3:0]    deb;
  logic [3:0]    pressed;
  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [1:0]    active, next_active;
  logic          first, next_first;
  logic [3:0]    keys_q, next_keys;
  logic          busy_q;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock    (clock),
      .resetApp (resetApp),
      .raw      (RawKey[i]),
      .debounced(deb[i])
    );
  end

  assign pressed = ~deb;

  // State, counter, latched key and registered outputs.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      active <= KEY_LEFT;
      first  <= 1'b0;
      keys_q <= {4{OFF}};
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      active <= next_active;
      first  <= next_first;
      keys_q <= next_keys;
      busy_q <= (next_state != ST_IDLE);
    end
  end

  // Next-state logic; the pulse always runs to completion, release is only
  // honoured in the OFF phases.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt + CW'(1);
    next_active = active;
    next_first  = first;
    next_keys   = {4{OFF}};
    case (state)
      ST_IDLE: begin
        next_cnt = '0;
        if (|pressed) begin
          next_active = pick_key(pressed);
          next_first  = 1'b1;
          next_state  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          next_cnt   = '0;
          next_first = 1'b0;
          next_state = first ? ST_DELAY : ST_REPEAT;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (deb[active] == OFF) begin
          next_cnt   = '0;
          next_state = ST_IDLE;
        end else if (cnt == ((state == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          next_cnt   = '0;
          next_state = ST_PULSE;
        end
      end
      default: begin
        next_cnt   = '0;
        next_state = ST_IDLE;
      end
    endcase
    if (next_state == ST_PULSE) next_keys[next_active] = ON;
  end

  assign KeyLeft  = keys_q[KEY_LEFT];
  assign KeyRight = keys_q[KEY_RIGHT];
  assign KeyUp    = keys_q[KEY_UP];
  assign KeyDown  = keys_q[KEY_DOWN];
  assign KeyBusy  = busy_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner with small timing parameters. Edges are
// numbered by edge_cnt; every expected output pulse is pushed as
// {key, start edge, length} and a monitor compares each observed pulse.
module tb_key_input_conditioner;

  logic       clock = 1'b0;
  logic       resetApp;
  logic [3:0] raw_key;
  logic       key_left, key_right, key_up, key_down, key_busy;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [25:0] exp_q[$];

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clock   (clock),
    .resetApp(resetApp),
    .RawKey  (raw_key),
    .KeyLeft (key_left),
    .KeyRight(key_right),
    .KeyUp   (key_up),
    .KeyDown (key_down),
    .KeyBusy (key_busy)
  );

  // Clock and edge numbering
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic logic [25:0] make_exp(input int key, input int start, input int len);
    logic [31:0] k, s, l;
    k = key; s = start; l = len;
    return {k[1:0], s[15:0], l[7:0]};
  endfunction

  task automatic push(input int key, input int start, input int len);
    exp_q.push_back(make_exp(key, start, len));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clock);
  endtask

  // Monitor: measures each ON pulse and scores it against the queue.
  logic [3:0]  prev_keys = 4'hF;
  logic [3:0]  cur_keys;
  int          start_edge[4];
  logic [25:0] got_item, exp_item;

  always @(negedge clock) begin
    cur_keys = {key_down, key_up, key_right, key_left};
    checks++;
    if ($countones(~cur_keys) > 1) begin
      failures++;
      $display("FAIL one_hot: outputs %b at edge %0d, at most one may be 0", cur_keys, edge_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      if (prev_keys[k] && !cur_keys[k]) start_edge[k] = edge_cnt;
      if (!prev_keys[k] && cur_keys[k]) begin
        got_item = make_exp(k, start_edge[k], edge_cnt - start_edge[k]);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected: key=%0d start=%0d len=%0d, none expected",
                   got_item[25:24], got_item[23:8], got_item[7:0]);
        end else begin
          exp_item = exp_q.pop_front();
          if (got_item !== exp_item) begin
            failures++;
            $display("FAIL pulse: key=%0d start=%0d len=%0d expected key=%0d start=%0d len=%0d",
                     got_item[25:24], got_item[23:8], got_item[7:0],
                     exp_item[25:24], exp_item[23:8], exp_item[7:0]);
          end
        end
      end
    end
    prev_keys = cur_keys;
  end

  int b, r;
  int hold_offs[7] = '{6, 19, 27, 35, 43, 51, 59};

  initial begin
    resetApp = 1'b0;
    raw_key  = 4'hF;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {key_down, key_up, key_right, key_left}, 4'hF);
    chk("reset_busy", key_busy, 1'b0);
    resetApp = 1'b1;
    repeat (3) @(negedge clock);

    // Short tap on Left: released long before the repeat delay expires.
    b = edge_cnt + 1;
    raw_key = 4'b1110;
    push(0, b + 6, 3);
    wait_edge(b + 5);  chk("tap_busy_before", key_busy, 1'b0);
                       chk("tap_left_before", key_left, 1'b1);
    wait_edge(b + 6);  chk("tap_busy_on", key_busy, 1'b1);
                       chk("tap_left_on", key_left, 1'b0);
    wait_edge(b + 7);  raw_key = 4'hF;
    wait_edge(b + 13); chk("tap_busy_delay", key_busy, 1'b1);
    wait_edge(b + 14); chk("tap_busy_idle", key_busy, 1'b0);
    wait_edge(b + 30);

    // Bouncing Up: never stable long enough to register.
    for (int i = 0; i < 15; i++) begin
      raw_key = (i % 2 == 0) ? 4'b1011 : 4'hF;
      repeat (2) @(negedge clock);
    end
    raw_key = 4'hF;
    repeat (10) @(negedge clock);
    chk("bounce_busy", key_busy, 1'b0);

    // Held Down: first pulse, repeat delay, then repeat period.
    b = edge_cnt + 1;
    raw_key = 4'b0111;
    foreach (hold_offs[i]) push(3, b + hold_offs[i], 3);
    wait_edge(b + 59); raw_key = 4'hF;
    wait_edge(b + 65); chk("hold_busy_repeat", key_busy, 1'b1);
    wait_edge(b + 66); chk("hold_busy_idle", key_busy, 1'b0);
    repeat (10) @(negedge clock);

    // All keys at once: Left wins; releasing Left hands over to Right.
    b = edge_cnt + 1;
    raw_key = 4'b0000;
    push(0, b + 6, 3);
    push(1, b + 15, 3);
    wait_edge(b + 7);  raw_key = 4'b0001;
    wait_edge(b + 14); chk("simul_idle_gap", key_busy, 1'b0);
                       chk("simul_right_off", key_right, 1'b1);
    wait_edge(b + 15); chk("simul_right_on", key_right, 1'b0);
    wait_edge(b + 16); raw_key = 4'hF;
    wait_edge(b + 40);
    chk("simul_busy_end", key_busy, 1'b0);

    // Reset during the second cycle of a pulse, key kept held.
    b = edge_cnt + 1;
    raw_key = 4'b1110;
    push(0, b + 6, 2);
    wait_edge(b + 7);
    #2 resetApp = 1'b0;
    #1 chk("rst_async_outputs", {key_down, key_up, key_right, key_left}, 4'hF);
    chk("rst_async_busy", key_busy, 1'b0);
    @(negedge clock);
    @(negedge clock);
    resetApp = 1'b1;
    r = edge_cnt + 1;
    push(0, r + 6, 3);
    wait_edge(r + 5);  chk("rst_left_before", key_left, 1'b1);
                       chk("rst_busy_before", key_busy, 1'b0);
    wait_edge(r + 6);  chk("rst_left_on", key_left, 1'b0);
    wait_edge(r + 9);  raw_key = 4'hF;
    wait_edge(r + 30);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_pulses: got %0d still queued, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
